// File: rtl/msm_scalar_recoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : msm_scalar_recoder_pkg
//  Purpose  : Shared constants, digit types and helpers for the MSM scalar
//             recoder (BLS12-377 bucket accumulator front end).
//  Contents : scalar / window geometry, signed digit type, beat type,
//             recoder state encoding, window index helper.
//  Revision : 1.0  initial release
// ============================================================================
package msm_scalar_recoder_pkg;

  // Scalar and window geometry
  localparam int P_FUL_SCLR_W   = 256;
  localparam int P_RED_SCLR_W   = 13;
  localparam int P_NUM_ACCU     = 3;
  localparam int P_TOTAL_WIN    = 20;
  localparam int P_NUM_WIN      = 7;

  localparam int P_DGT_W        = P_RED_SCLR_W;
  localparam int P_RECODE_BEATS = P_NUM_WIN;

  // One buffer holds every lane/beat slot, including the always-zero window 20
  localparam int P_BUF_DGTS     = P_NUM_ACCU * P_NUM_WIN;
  // Windows recoded per RECODE cycle (depth of the carry ripple)
  localparam int P_WIN_PER_CYC  = 3;
  // Scalar zero-extended so every buffer slot has a slice behind it
  localparam int P_PAD_SCLR_W   = P_BUF_DGTS * P_DGT_W;
  localparam int P_WIN_IDX_W    = 5;
  localparam int P_BEAT_W       = 3;

  typedef struct packed {
    logic               neg;
    logic [P_DGT_W-1:0] mag;
  } dgt_t;

  typedef dgt_t [P_NUM_ACCU-1:0] dgt_beat_t;

  typedef enum logic [0:0] {
    RC_IDLE   = 1'b0,
    RC_RECODE = 1'b1
  } rc_state_e;

  // Lane a on beat w carries window a*P_NUM_WIN + w
  function automatic logic [P_WIN_IDX_W-1:0] win_index(input int unsigned lane,
                                                       input logic [P_BEAT_W-1:0] beat);
    return P_WIN_IDX_W'(lane * P_NUM_WIN) + P_WIN_IDX_W'(beat);
  endfunction

endpackage
`default_nettype wire

// File: rtl/msm_scalar_recoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : msm_scalar_recoder_if
//  Purpose  : Scalar input stream and digit output stream of the recoder.
//  Signals  : s_sclr_valid/ready/data/last  - scalar stream (into recoder)
//             m_dgt_valid/ready/mag/neg/win/last - digit beat stream (out)
//  Modports : slave  - the recoder itself
//             master - the environment (scalar source and digit sink)
//  Revision : 1.0  initial release
// ============================================================================
interface msm_scalar_recoder_if
  import msm_scalar_recoder_pkg::*;
  ;

  logic                          s_sclr_valid;
  logic                          s_sclr_ready;
  logic [P_FUL_SCLR_W-1:0]       s_sclr_data;
  logic                          s_sclr_last;

  logic                          m_dgt_valid;
  logic                          m_dgt_ready;
  logic [P_NUM_ACCU*P_DGT_W-1:0] m_dgt_mag;
  logic [P_NUM_ACCU-1:0]         m_dgt_neg;
  logic [P_BEAT_W-1:0]           m_dgt_win;
  logic                          m_dgt_last;

  modport slave (
    input  s_sclr_valid, s_sclr_data, s_sclr_last, m_dgt_ready,
    output s_sclr_ready, m_dgt_valid, m_dgt_mag, m_dgt_neg, m_dgt_win, m_dgt_last
  );

  modport master (
    output s_sclr_valid, s_sclr_data, s_sclr_last, m_dgt_ready,
    input  s_sclr_ready, m_dgt_valid, m_dgt_mag, m_dgt_neg, m_dgt_win, m_dgt_last
  );

endinterface
`default_nettype wire

// File: rtl/msm_win_recode_lane.sv
`default_nettype none
// ============================================================================
//  Module   : msm_win_recode_lane
//  Purpose  : Combinational recoding of three consecutive windows with a
//             rippled carry. Signed mode: t = slice + carry; t >= 2^12 gives
//             digit t - 2^13 with carry out 1, otherwise digit t, carry 0.
//  Ports    : slice_i [3 x 13]  raw window slices, lowest window at index 0
//             carry_i           carry into the lowest window
//             dgt_o   [3]       sign/magnitude digits
//             carry_o           carry out of the highest window
//  Config   : MSM_RECODE_UNSIGNED_EN - plain unsigned slicing, no carries
//  Revision : 1.0  initial release
// ============================================================================
module msm_win_recode_lane
  import msm_scalar_recoder_pkg::*;
(
  input  logic [P_WIN_PER_CYC-1:0][P_DGT_W-1:0] slice_i,
  input  logic                                  carry_i,
  output dgt_t [P_WIN_PER_CYC-1:0]              dgt_o,
  output logic                                  carry_o
);

`ifdef MSM_RECODE_UNSIGNED_EN

  always_comb begin
    dgt_o   = '0;
    carry_o = 1'b0;
    for (int j = 0; j < P_WIN_PER_CYC; j++) begin
      dgt_o[j].mag = slice_i[j];
      dgt_o[j].neg = 1'b0;
    end
  end

`else

  localparam int               P_T_W  = P_DGT_W + 1;
  localparam logic [P_T_W-1:0] C_HALF = P_T_W'(1) << (P_DGT_W - 1);
  localparam logic [P_T_W-1:0] C_FULL = P_T_W'(1) << P_DGT_W;

  always_comb begin : p_recode
    logic             c;
    logic [P_T_W-1:0] t;
    logic [P_T_W-1:0] nmag;
    dgt_o   = '0;
    carry_o = 1'b0;
    c       = carry_i;
    t       = '0;
    nmag    = '0;
    for (int j = 0; j < P_WIN_PER_CYC; j++) begin
      t = {1'b0, slice_i[j]} + P_T_W'(c);
      if (t >= C_HALF) begin
        // Negative digit: |t - 2^13| = 2^13 - t, at most 4096 so it fits.
        // t = 2^13 yields digit 0, which is reported as non-negative.
        nmag         = C_FULL - t;
        dgt_o[j].mag = nmag[P_DGT_W-1:0];
        dgt_o[j].neg = |nmag;
        c            = 1'b1;
      end else begin
        dgt_o[j].mag = t[P_DGT_W-1:0];
        dgt_o[j].neg = 1'b0;
        c            = 1'b0;
      end
    end
    carry_o = c;
  end

`endif

endmodule
`default_nettype wire

// File: rtl/msm_scalar_recoder.sv
`default_nettype none
// ============================================================================
//  Module   : msm_scalar_recoder
//  Purpose  : Recodes 256-bit scalars into 20 signed 13-bit window digits and
//             streams them as 7 beats of 3 lane digits (lane a, beat w carries
//             window a*7+w; window 20 is always zero). Two ping-pong digit
//             buffers decouple recoding from downstream back-pressure.
//  Ports    : clk      kernel clock
//             rst      synchronous active-high reset
//             bus_io   slave side of msm_scalar_recoder_if
//                      (scalar stream in, digit beat stream out)
//  Config   : MSM_RECODE_UNSIGNED_EN - unsigned slicing instead of signed
//             recoding (no carries, neg always 0)
//  Revision : 1.0  initial release
// ============================================================================
module msm_scalar_recoder
  import msm_scalar_recoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  msm_scalar_recoder_if.slave  bus_io
);

  localparam logic [P_BEAT_W-1:0] C_LAST_STEP = P_BEAT_W'(P_RECODE_BEATS - 1);

  // Recoder state
  rc_state_e               state_q, state_d;
  logic [P_BEAT_W-1:0]     step_q, step_d;
  logic [P_PAD_SCLR_W-1:0] sclr_q;
  logic                    carry_q;
  logic                    last_in_q;

  // Ping-pong buffers
  logic                    wr_ptr_q;
  logic                    rd_ptr_q;
  logic [1:0]              full_q;
  logic [1:0]              last_q;
  logic [P_BEAT_W-1:0]     win_q;
  dgt_t                    dgt_buf_q [2][P_BUF_DGTS];

  logic                                  w_hs_in;
  logic                                  w_hs_out;
  logic                                  w_out_valid;
  logic                                  w_drain_fin;
  logic                                  w_rc_last;
  logic                                  w_tgt;
  logic                                  w_tgt_free;
  logic [P_WIN_PER_CYC-1:0][P_DGT_W-1:0] w_slice;
  dgt_t [P_WIN_PER_CYC-1:0]              w_dgt;
  logic                                  w_carry;
  dgt_beat_t                             w_rd_beat;

  // --------------------------------------------------------------------------
  // Handshakes and input acceptance
  // --------------------------------------------------------------------------
  assign w_out_valid = full_q[rd_ptr_q];
  assign w_hs_out    = w_out_valid & bus_io.m_dgt_ready;
  assign w_drain_fin = w_hs_out & (win_q == C_LAST_STEP);
  assign w_rc_last   = (state_q == RC_RECODE) & (step_q == C_LAST_STEP);

  // During RECODE the buffer being written is wr_ptr_q, so the next scalar
  // will land in the other one.
  assign w_tgt       = (state_q == RC_RECODE) ? ~wr_ptr_q : wr_ptr_q;
  assign w_tgt_free  = ~full_q[w_tgt] | (w_drain_fin & (rd_ptr_q == w_tgt));

  assign bus_io.s_sclr_ready = ~rst & ((state_q == RC_IDLE) | w_rc_last) & w_tgt_free;
  assign w_hs_in             = bus_io.s_sclr_valid & bus_io.s_sclr_ready;

  // --------------------------------------------------------------------------
  // Recode datapath: the latched scalar shifts down three windows per cycle,
  // so the lane always sees the current three slices at the bottom.
  // --------------------------------------------------------------------------
  for (genvar j = 0; j < P_WIN_PER_CYC; j++) begin : g_slice
    assign w_slice[j] = sclr_q[j*P_DGT_W +: P_DGT_W];
  end

  msm_win_recode_lane u_lane (
    .slice_i (w_slice),
    .carry_i (carry_q),
    .dgt_o   (w_dgt),
    .carry_o (w_carry)
  );

  // --------------------------------------------------------------------------
  // Recoder FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      RC_IDLE: begin
        if (w_hs_in) begin
          state_d = RC_RECODE;
          step_d  = '0;
        end
      end
      RC_RECODE: begin
        if (step_q == C_LAST_STEP) begin
          // A new scalar may be accepted on the last recode cycle
          state_d = w_hs_in ? RC_RECODE : RC_IDLE;
          step_d  = '0;
        end else begin
          step_d  = step_q + 1'b1;
        end
      end
      default: begin
        state_d = RC_IDLE;
        step_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RC_IDLE;
      step_q    <= '0;
      sclr_q    <= '0;
      carry_q   <= 1'b0;
      last_in_q <= 1'b0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      full_q    <= '0;
      last_q    <= '0;
      win_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;

      if (w_hs_in) begin
        sclr_q    <= P_PAD_SCLR_W'(bus_io.s_sclr_data);
        carry_q   <= 1'b0;
        last_in_q <= bus_io.s_sclr_last;
      end else if (state_q == RC_RECODE) begin
        sclr_q  <= sclr_q >> (P_WIN_PER_CYC * P_DGT_W);
        carry_q <= w_carry;
      end

      // Completion and drain always touch different buffers
      if (w_rc_last) begin
        full_q[wr_ptr_q] <= 1'b1;
        last_q[wr_ptr_q] <= last_in_q;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (w_drain_fin) begin
        full_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q         <= ~rd_ptr_q;
      end

      if (w_hs_out) begin
        win_q <= (win_q == C_LAST_STEP) ? '0 : win_q + 1'b1;
      end
    end
  end

  // Digit storage needs no reset: contents are only visible while full_q is set
  always_ff @(posedge clk) begin
    if (state_q == RC_RECODE) begin
      for (int i = 0; i < P_BUF_DGTS; i++) begin
        if (step_q == P_BEAT_W'(i / P_WIN_PER_CYC)) begin
          dgt_buf_q[wr_ptr_q][i] <= w_dgt[i % P_WIN_PER_CYC];
        end
      end
    end
  end

`ifndef MSM_RECODE_UNSIGNED_EN
  // Window 19 has only 9 bits, so it can never produce a carry; window 20's
  // digit equals that carry and must therefore stay zero.
  always_ff @(posedge clk) begin
    if (!rst && w_rc_last) begin
      assert (w_dgt[P_WIN_PER_CYC-1] == '0);
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Output beat
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd_beat = '0;
    for (int a = 0; a < P_NUM_ACCU; a++) begin
      w_rd_beat[a] = dgt_buf_q[rd_ptr_q][win_index(a, win_q)];
    end
  end

  for (genvar a = 0; a < P_NUM_ACCU; a++) begin : g_out
    assign bus_io.m_dgt_mag[a*P_DGT_W +: P_DGT_W] = w_out_valid ? w_rd_beat[a].mag : '0;
    assign bus_io.m_dgt_neg[a]                    = w_out_valid & w_rd_beat[a].neg;
  end

  assign bus_io.m_dgt_valid = w_out_valid;
  assign bus_io.m_dgt_win   = w_out_valid ? win_q : '0;
  assign bus_io.m_dgt_last  = w_out_valid & last_q[rd_ptr_q] & (win_q == C_LAST_STEP);

endmodule
`default_nettype wire
